// File: rtl/prf_pkg.sv
// prf_pkg: shared types and constants for the pulse-repetition sequencer.
package prf_pkg;
  localparam int PRF_CNT_W      = 16;
  localparam int PRF_MIN_PERIOD = 32;
  localparam logic [1:0] REG_BURST  = 2'd0;
  localparam logic [1:0] REG_DELAY  = 2'd1;
  localparam logic [1:0] REG_GATE   = 2'd2;
  localparam logic [1:0] REG_PERIOD = 2'd3;
  typedef enum logic [2:0] {IDLE, BURST, DELAY, GATE, HOLD} state_e;
endpackage

// File: rtl/prf_cfg_regs.sv
// prf_cfg_regs: shadow timing registers, legality check and boundary load into the active set.
module prf_cfg_regs
  import prf_pkg::*;
#(
  parameter int CNT_W      = PRF_CNT_W,
  parameter int MIN_PERIOD = PRF_MIN_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             load_req,
  output logic [CNT_W-1:0] act_burst,
  output logic [CNT_W-1:0] act_delay,
  output logic [CNT_W-1:0] act_gate,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] nxt_burst,
  output logic [CNT_W-1:0] nxt_delay,
  output logic [CNT_W-1:0] nxt_gate,
  output logic [CNT_W-1:0] nxt_period,
  output logic             err_cfg
);
  logic [CNT_W-1:0] sh_b_q, sh_b_d, sh_d_q, sh_d_d, sh_g_q, sh_g_d, sh_p_q, sh_p_d;
  logic [CNT_W-1:0] act_b_q, act_d_q, act_g_q, act_p_q;
  logic [CNT_W+1:0] sum;
  logic             pend_q, pend_d, err_q, err_d, legal, load;
  always_comb begin
    sh_b_d = (cfg_wr && cfg_addr == REG_BURST)  ? cfg_data : sh_b_q;
    sh_d_d = (cfg_wr && cfg_addr == REG_DELAY)  ? cfg_data : sh_d_q;
    sh_g_d = (cfg_wr && cfg_addr == REG_GATE)   ? cfg_data : sh_g_q;
    sh_p_d = (cfg_wr && cfg_addr == REG_PERIOD) ? cfg_data : sh_p_q;
    sum    = {2'b00, sh_b_q} + {2'b00, sh_d_q} + {2'b00, sh_g_q};
    legal  = (sum < {2'b00, sh_p_q}) && (sh_p_q >= CNT_W'(MIN_PERIOD));
    // Only a shadow touched since the last attempt is checked, so reset leaves err_cfg low.
    load   = load_req && pend_q;
    pend_d = cfg_wr || (pend_q && !load);
    err_d  = err_q || (load && !legal);
    nxt_burst  = (load && legal) ? sh_b_q : act_b_q;
    nxt_delay  = (load && legal) ? sh_d_q : act_d_q;
    nxt_gate   = (load && legal) ? sh_g_q : act_g_q;
    nxt_period = (load && legal) ? sh_p_q : act_p_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_b_q  <= '0;
      sh_d_q  <= '0;
      sh_g_q  <= '0;
      sh_p_q  <= '0;
      act_b_q <= '0;
      act_d_q <= '0;
      act_g_q <= '0;
      act_p_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sh_b_q  <= sh_b_d;
      sh_d_q  <= sh_d_d;
      sh_g_q  <= sh_g_d;
      sh_p_q  <= sh_p_d;
      act_b_q <= nxt_burst;
      act_d_q <= nxt_delay;
      act_g_q <= nxt_gate;
      act_p_q <= nxt_period;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end
  assign act_burst  = act_b_q;
  assign act_delay  = act_d_q;
  assign act_gate   = act_g_q;
  assign act_period = act_p_q;
  assign err_cfg    = err_q;
endmodule

// File: rtl/prf_sequencer.sv
// prf_sequencer: per-firing burst/ADC/sample-gate enables on a programmable PRF period,
// throttled by the sample FIFO almost-full flag.
module prf_sequencer
  import prf_pkg::*;
#(
  parameter int CNT_W      = PRF_CNT_W,
  parameter int MIN_PERIOD = PRF_MIN_PERIOD
) (
  input  logic             CLK_64MHz,
  input  logic             nRESET,
  input  logic             nENABLE,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             fifo_afull,
  output logic             BURST_EN,
  output logic             ADC_EN,
  output logic             SMPL_EN,
  output logic             prf_tick,
  output logic             halted,
  output logic             err_cfg
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d, burst_q, burst_d, adc_q, adc_d, smpl_q, smpl_d;
  logic [CNT_W-1:0] b_q, d_q, g_q, p_q, b_n, d_n, g_n, p_n;
  logic             run, en, wrap, start, load_req;
  prf_cfg_regs #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD)) u_cfg (
    .clk(CLK_64MHz), .rst_n(nRESET), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .load_req(load_req),
    .act_burst(b_q), .act_delay(d_q), .act_gate(g_q), .act_period(p_q),
    .nxt_burst(b_n), .nxt_delay(d_n), .nxt_gate(g_n), .nxt_period(p_n),
    .err_cfg(err_cfg)
  );
  // Phase owning position c of a period; zero-length phases simply never match.
  function automatic state_e phase(input logic [CNT_W-1:0] c, b, d, g);
    logic [CNT_W+1:0] c2, e1, e2, e3;
    c2 = {2'b00, c};
    e1 = {2'b00, b};
    e2 = e1 + {2'b00, d};
    e3 = e2 + {2'b00, g};
    return (c2 < e1) ? BURST : (c2 < e2) ? DELAY : (c2 < e3) ? GATE : HOLD;
  endfunction
  always_comb begin
    sync_d   = {sync_q[0], nENABLE};
    run      = state_q != IDLE;
    en       = !sync_q[1];
    wrap     = run && cnt_q == p_q - ONE;
    load_req = wrap || (!run && en);
    start    = wrap || (!run && en && p_n != '0);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    if (run && !en) begin
      state_d = IDLE;
      cnt_d   = '0;
      halt_d  = 1'b0;
    end else if (start) begin
      cnt_d   = '0;
      halt_d  = fifo_afull;
      state_d = fifo_afull ? HOLD : phase('0, b_n, d_n, g_n);
    end else if (run) begin
      cnt_d   = cnt_q + ONE;
      state_d = halt_q ? HOLD : phase(cnt_q + ONE, b_q, d_q, g_q);
    end
  end
  always_comb begin
    burst_d = state_q == BURST;
    adc_d   = state_q == DELAY || state_q == GATE;
    smpl_d  = state_q == GATE;
  end
  always_ff @(posedge CLK_64MHz or negedge nRESET) begin
    if (!nRESET) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      burst_q <= 1'b0;
      adc_q   <= 1'b0;
      smpl_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      burst_q <= burst_d;
      adc_q   <= adc_d;
      smpl_q  <= smpl_d;
    end
  end
  assign BURST_EN = burst_q;
  assign ADC_EN   = adc_q;
  assign SMPL_EN  = smpl_q;
  assign prf_tick = run && cnt_q == '0;
  assign halted   = halt_q;
endmodule

// File: tb/tb_prf_sequencer.sv
// tb_prf_sequencer: random and directed stimulus against a period-position reference model.
module tb_prf_sequencer;
  logic clk = 1'b0;
  logic rst_n, n_en, wr, afull;
  logic [1:0] addr;
  logic [15:0] data;
  logic burst_en, adc_en, smpl_en, tick, halted, err;
  int checks = 0;
  int errors = 0;
  bit m_s1, m_s2, m_pend, m_err, m_run, m_halt, m_b, m_a, m_s;
  int m_pos;
  int m_sh[4];
  int m_act[4];

  prf_sequencer dut (
    .CLK_64MHz(clk), .nRESET(rst_n), .nENABLE(n_en), .cfg_wr(wr), .cfg_addr(addr),
    .cfg_data(data), .fifo_afull(afull), .BURST_EN(burst_en), .ADC_EN(adc_en),
    .SMPL_EN(smpl_en), .prf_tick(tick), .halted(halted), .err_cfg(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    {m_s1, m_s2, m_pend, m_err, m_run, m_halt, m_b, m_a, m_s} = '0;
    m_pos = 0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = 0;
      m_act[i] = 0;
    end
  endtask

  // 1 burst, 2 delay, 3 gate, 4 hold for a position inside the active period
  function automatic int ph(input int pos);
    if (pos < m_act[0]) return 1;
    if (pos < m_act[0] + m_act[1]) return 2;
    if (pos < m_act[0] + m_act[1] + m_act[2]) return 3;
    return 4;
  endfunction

  task automatic model_step();
    bit en, wrap, ld, ok;
    int cur;
    if (!rst_n) begin
      model_reset();
      return;
    end
    en   = !m_s2;
    cur  = !m_run ? 0 : m_halt ? 4 : ph(m_pos);
    wrap = m_run && m_pos == m_act[3] - 1;
    ld   = m_pend && (wrap || (!m_run && en));
    ok   = (m_sh[0] + m_sh[1] + m_sh[2] < m_sh[3]) && m_sh[3] >= 32;
    if (ld && ok) m_act = m_sh;
    if (ld && !ok) m_err = 1'b1;
    m_pend = wr || (m_pend && !ld);
    if (wr) m_sh[addr] = int'(data);
    m_b = cur == 1;
    m_a = cur == 2 || cur == 3;
    m_s = cur == 3;
    if (m_run && !en) begin
      m_run = 1'b0;
      m_pos = 0;
      m_halt = 1'b0;
    end else if (wrap || (!m_run && en && m_act[3] != 0)) begin
      m_run = 1'b1;
      m_pos = 0;
      m_halt = afull;
    end else if (m_run) m_pos++;
    m_s2 = m_s1;
    m_s1 = n_en;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk("tick", 32'(tick), 32'(m_run && m_pos == 0));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("burst", 32'(burst_en), 32'(m_b));
    chk("adc", 32'(adc_en), 32'(m_a));
    chk("smpl", 32'(smpl_en), 32'(m_s));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic run_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic wcfg(input int a, input int d);
    wr = 1'b1;
    addr = 2'(a);
    data = 16'(d);
    cyc();
    wr = 1'b0;
  endtask

  task automatic wait_hi(input int sel, input int lim);
    int k;
    k = 0;
    while (((sel == 0) ? burst_en : smpl_en) !== 1'b1 && k < lim) begin
      cyc();
      k++;
    end
    chk("wait_ok", 32'(k < lim), 1);
  endtask

  initial begin
    int r, a, v, sc;
    rst_n = 1'b0; n_en = 1'b1; wr = 1'b0; addr = '0; data = '0; afull = 1'b0;
    model_reset();
    run_n(3);
    rst_n = 1'b1;
    run_n(4);
    wcfg(0, 4); wcfg(1, 10); wcfg(2, 8); wcfg(3, 100);
    n_en = 1'b0;
    run_n(250);
    wcfg(3, 200);
    run_n(450);
    wcfg(0, 50); wcfg(1, 30); wcfg(2, 20); wcfg(3, 100);
    run_n(450);
    chk("err_sticky", 32'(err), 1);
    wcfg(0, 4); wcfg(1, 10); wcfg(2, 8); wcfg(3, 16);
    run_n(250);
    wcfg(3, 100);
    run_n(250);
    afull = 1'b1;
    run_n(150);
    afull = 1'b0;
    run_n(250);
    wait_hi(1, 300);
    n_en = 1'b1;
    run_n(5);
    chk("dis_smpl", 32'(smpl_en), 0);
    chk("dis_adc", 32'(adc_en), 0);
    n_en = 1'b0;
    run_n(250);
    repeat (2500) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        a = int'($urandom_range(0, 3));
        v = (a == 3) ? int'($urandom_range(20, 140)) : int'($urandom_range(0, 30));
        wcfg(a, v);
      end else if (r < 5) afull = ~afull;
      else if (r == 5) n_en = ~n_en;
      else cyc();
    end
    n_en = 1'b0; afull = 1'b0;
    wcfg(0, 4); wcfg(1, 10); wcfg(2, 8); wcfg(3, 100);
    run_n(250);
    wait_hi(0, 300);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_burst", 32'(burst_en), 0);
    chk("arst_adc", 32'(adc_en), 0);
    chk("arst_smpl", 32'(smpl_en), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_err", 32'(err), 0);
    model_reset();
    run_n(2);
    rst_n = 1'b1;
    n_en = 1'b1;
    run_n(5);
    wcfg(0, 4); wcfg(1, 12); wcfg(2, 0); wcfg(3, 64);
    n_en = 1'b0;
    sc = 0;
    repeat (300) begin
      cyc();
      if (smpl_en === 1'b1) sc++;
    end
    chk("gate0_smpl_cnt", sc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
